// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter : writeback scheduler shared by the execution units.
//
// Every cycle the arbiter looks at each unit's head window and grants up to
// wwd results.  A unit can only give up a contiguous run of valid entries that
// starts at index 0, so its claim vector is always a prefix.  The granted
// entries are packed into the writeback slots in visit order and registered.
// Units are visited round-robin, starting at rr_ptr, so that no unit
// monopolises the writeback bandwidth.
//
// Ports
//   clk_i     clock
//   rst_i     synchronous reset, active-high
//   flush_i   pipeline flush; clears wb/rr_ptr and suppresses claims
//   wb_rdy_i  downstream accepts writeback this cycle
//   resp_i    unit head windows, entry valid iff opid[15]
//   claim_o   per-unit claim prefix (combinational, the unit dequeues on it)
//   wb_o      registered writeback bundles, slot valid iff opid[15]
//   rr_ptr_o  current round-robin start unit
//
// Optional feature: define WB_STARVE_GUARD_EN to add per-unit starvation
// counters.  A unit that has had work but no grant for stv cycles is visited
// first, overriding rr_ptr.  Without the macro the arbiter is pure round-robin.
// -----------------------------------------------------------------------------

package wb_arbiter_pkg;
    typedef struct packed {
        logic [15:0] opid;
        logic [31:0] data;
    } exe_bundle_t;
endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int nfu = 3,
    parameter int ewd = 4,
    parameter int wwd = 4,
    parameter int stv = 8,
    localparam int PW = (nfu > 1) ? $clog2(nfu) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              wb_rdy_i,
    input  exe_bundle_t [nfu-1:0][ewd-1:0]    resp_i,
    output logic        [nfu-1:0][ewd-1:0]    claim_o,
    output exe_bundle_t [wwd-1:0]             wb_o,
    output logic        [PW-1:0]              rr_ptr_o
);

    localparam int CW = $clog2(ewd + 1);

    logic        [nfu-1:0][CW-1:0]  run_len;
    logic        [nfu-1:0][ewd-1:0] claim_d;
    logic        [nfu-1:0]          grant_u;
    exe_bundle_t [wwd-1:0]          wb_d;
    exe_bundle_t [wwd-1:0]          wb_q;
    logic        [PW-1:0]           rr_ptr_q;
    logic        [PW-1:0]           start_idx;
    logic        [PW-1:0]           next_ptr;

    int sel_left;
    int sel_pos;
    int sel_u;

    // Length of the valid run from entry 0: the lowest invalid index wins.
    always_comb begin
        for (int u = 0; u < nfu; u++) begin
            run_len[u] = CW'(ewd);
            for (int i = ewd - 1; i >= 0; i--) begin
                if (!resp_i[u][i].opid[15]) begin
                    run_len[u] = CW'(i);
                end
            end
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(stv) + 1;

    logic [nfu-1:0][SW-1:0] cnt_q;

    // A starved unit jumps the queue; the lowest index wins among several.
    always_comb begin
        start_idx = rr_ptr_q;
        for (int u = nfu - 1; u >= 0; u--) begin
            if (cnt_q[u] >= SW'(stv)) begin
                start_idx = PW'(u);
            end
        end
    end

    // Counters freeze under backpressure so stalls do not count as starvation.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            cnt_q <= '0;
        end else if (wb_rdy_i) begin
            for (int u = 0; u < nfu; u++) begin
                if (grant_u[u]) begin
                    cnt_q[u] <= '0;
                end else if ((run_len[u] != '0) && (cnt_q[u] < SW'(stv))) begin
                    cnt_q[u] <= cnt_q[u] + 1'b1;
                end
            end
        end
    end
`else
    assign start_idx = rr_ptr_q;
`endif

    // Visit units from start_idx, hand each the lesser of its run and the
    // slots still free, and pack granted entries in visit order.
    always_comb begin
        claim_d  = '0;
        grant_u  = '0;
        wb_d     = '0;
        sel_left = wwd;
        sel_pos  = 0;
        sel_u    = 0;
        if (wb_rdy_i) begin
            for (int v = 0; v < nfu; v++) begin
                sel_u = (int'(start_idx) + v) % nfu;
                for (int i = 0; i < ewd; i++) begin
                    if ((i < int'(run_len[sel_u])) && (sel_left > 0)) begin
                        claim_d[sel_u][i] = 1'b1;
                        grant_u[sel_u]    = 1'b1;
                        wb_d[sel_pos]     = resp_i[sel_u][i];
                        sel_pos           = sel_pos + 1;
                        sel_left          = sel_left - 1;
                    end
                end
            end
        end
    end

    assign next_ptr = (start_idx == PW'(nfu - 1)) ? '0 : start_idx + 1'b1;

    // Flush and reset take priority so nothing is dequeued in that cycle.
    assign claim_o = (rst_i || flush_i) ? '0 : claim_d;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wb_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            wb_q <= wb_d;
            if (|grant_u) begin
                rr_ptr_q <= next_ptr;
            end
        end
    end

    assign wb_o     = wb_q;
    assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter : self-checking bench for wb_arbiter.
// A queue-based reference model derives the expected claims, the packed
// writeback slots and the round-robin pointer from the scheduling rules.
// Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NFU = 3;
    localparam int EWD = 4;
    localparam int WWD = 4;
    localparam int STV = 8;
    localparam int PW  = $clog2(NFU);

    logic                           clk;
    logic                           rst;
    logic                           flush;
    logic                           wb_rdy;
    exe_bundle_t [NFU-1:0][EWD-1:0] resp;
    logic        [NFU-1:0][EWD-1:0] claim;
    exe_bundle_t [WWD-1:0]          wb;
    logic        [PW-1:0]           rr_ptr;

    int n_vec = 0;
    int n_err = 0;

    exe_bundle_t [WWD-1:0] m_wb;
    int                    m_rr;
    int                    m_cnt [NFU];

    wb_arbiter #(.nfu(NFU), .ewd(EWD), .wwd(WWD), .stv(STV)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush),
        .wb_rdy_i (wb_rdy),
        .resp_i   (resp),
        .claim_o  (claim),
        .wb_o     (wb),
        .rr_ptr_o (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Fill one unit's window; mask bit i sets the valid flag of entry i.
    task automatic set_unit(input int u, input logic [EWD-1:0] mask);
        for (int i = 0; i < EWD; i++) begin
            resp[u][i].opid = {mask[i], 15'($urandom)};
            resp[u][i].data = $urandom;
        end
    endtask

    function automatic int lead_valid(input int u);
        int k = 0;
        while (k < EWD && resp[u][k].opid[15]) k++;
        return k;
    endfunction

    // Reference: walk units in rotation and take valid entries into a
    // writeback queue until an invalid entry or a full queue stops it.
    task automatic model_step(input logic r, input logic f, input logic rdy,
                              output logic [NFU-1:0][EWD-1:0] cl);
        exe_bundle_t q[$];
        int start;
        int g [NFU];
        cl    = '0;
        start = m_rr;
        for (int u = 0; u < NFU; u++) g[u] = 0;
`ifdef WB_STARVE_GUARD_EN
        for (int u = NFU - 1; u >= 0; u--) if (m_cnt[u] >= STV) start = u;
`endif
        if (!r && !f && rdy) begin
            for (int v = 0; v < NFU; v++) begin
                int u = (start + v) % NFU;
                for (int i = 0; i < EWD; i++) begin
                    if (!resp[u][i].opid[15] || q.size() >= WWD) break;
                    q.push_back(resp[u][i]);
                    cl[u][i] = 1'b1;
                    g[u]++;
                end
            end
        end
        if (r || f) begin
            m_wb = '0;
            m_rr = 0;
            for (int u = 0; u < NFU; u++) m_cnt[u] = 0;
        end else begin
            m_wb = '0;
            for (int s = 0; s < q.size(); s++) m_wb[s] = q[s];
            if (q.size() > 0) m_rr = (start + 1) % NFU;
            if (rdy) begin
                for (int u = 0; u < NFU; u++) begin
                    if (g[u] > 0) m_cnt[u] = 0;
                    else if (lead_valid(u) > 0 && m_cnt[u] < STV) m_cnt[u]++;
                end
            end
        end
    endtask

    task automatic apply(input logic r, input logic f, input logic rdy);
        logic [NFU-1:0][EWD-1:0] exp_cl;
        rst    = r;
        flush  = f;
        wb_rdy = rdy;
        #1;
        model_step(r, f, rdy, exp_cl);
        chk("claim", claim, exp_cl);
        @(posedge clk);
        #1;
        chk("wb", wb, m_wb);
        chk("rr_ptr", rr_ptr, m_rr);
    endtask

    task automatic rand_unit(input int u);
        logic [EWD-1:0] mask;
        int k;
        k    = $urandom_range(0, EWD);
        mask = EWD'($urandom);
        case ($urandom_range(0, 3))
            0: mask = '0;
            1: mask = '1;
            2: begin
                for (int i = 0; i < EWD; i++) begin
                    if (i < k) mask[i] = 1'b1;
                    else if (i == k) mask[i] = 1'b0;
                end
            end
            default: ;
        endcase
        set_unit(u, mask);
    endtask

    initial begin
        m_wb = '0;
        m_rr = 0;
        for (int u = 0; u < NFU; u++) m_cnt[u] = 0;
        rst = 1'b1; flush = 1'b0; wb_rdy = 1'b1;
        for (int u = 0; u < NFU; u++) set_unit(u, '1);

        // Reset with every unit full.
        apply(1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b1);

        // Single unit with a run of three.
        set_unit(0, 4'b0111); set_unit(1, '0); set_unit(2, '0);
        apply(1'b0, 1'b0, 1'b1);

        // Full contention, rotation 1 -> 2 -> 0 -> 1.
        for (int c = 0; c < 3; c++) begin
            for (int u = 0; u < NFU; u++) set_unit(u, '1);
            apply(1'b0, 1'b0, 1'b1);
        end

        // Hole in the window.
        set_unit(0, '0); set_unit(1, '0); set_unit(2, 4'b1011);
        apply(1'b0, 1'b0, 1'b1);

        // Empty cycle: pointer must hold.
        set_unit(2, '0);
        apply(1'b0, 1'b0, 1'b1);

        // Backpressure, then flush in a granting cycle.
        for (int u = 0; u < NFU; u++) set_unit(u, '1);
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1);

        // Partial contention: total valid just over the slot count.
        set_unit(0, 4'b0011); set_unit(1, 4'b0001); set_unit(2, 4'b0111);
        apply(1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int u = 0; u < NFU; u++) rand_unit(u);
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
